fft_output: RTL and testbench

Reader end of the FFT result memory: after the transform completes, it drains the N-point result RAM two complex words per cycle and streams them out in pairs with valid/ready backpressure. It sits opposite the input stage, which writes sample pairs to even/odd addresses. It is the last block before the system output port. It owns the memory read ports, pipelines the 1-cycle synchronous RAM read latency, and absorbs downstream stalls without dropping data.

---
 rtl/fft_output.sv | 151 +++++++++++++++
 tb/tb_fft_output.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output.sv
// Reader end of the FFT result RAM: drains N points two words per cycle into a
// 2-deep output FIFO with valid/ready backpressure. Define FFT_OUT_BITREV_EN to
// read a bit-reversed RAM in natural order.
module fft_output #(
    parameter int N             = 32,
    parameter int word_size     = 16,
    parameter int address_width = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       start,
    output logic                       rd_en,
    output logic [address_width-1:0]   rd_addr1,
    output logic [address_width-1:0]   rd_addr2,
    input  logic [2*word_size-1:0]     rd_data1,
    input  logic [2*word_size-1:0]     rd_data2,
    output logic [2*word_size-1:0]     out1,
    output logic [2*word_size-1:0]     out2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    // state | meaning
    // IDLE  | waiting for start, FIFO empty
    // READ  | issuing pair reads k = 0..N/2-1 as FIFO space allows
    // DRAIN | all reads issued, emptying FIFO and in-flight read

    localparam int PAIRS = N / 2;
    localparam int KW    = address_width - 1;
    localparam int DW    = 2 * word_size;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [KW-1:0]            k_q;
    logic                     inflight_q;
    logic [1:0]               count_q;
    logic [DW-1:0]            tail1_q;
    logic [DW-1:0]            tail2_q;
    logic                     pop;
    logic                     push;
    logic                     last_issue;
    logic                     drain_exit;
    logic [2:0]               occupancy;
    logic [address_width-1:0] idx1;
    logic [address_width-1:0] idx2;

    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid & out_ready & en;
    assign push       = inflight_q;
    // slots claimed after this cycle's pop; a new read only if one stays free
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en      = (state_q == READ) && en && (occupancy < 3'd2);
    assign last_issue = rd_en && (k_q == KW'(PAIRS - 1));
    assign drain_exit = (state_q == DRAIN) && en && (count_q == 2'd0) && !inflight_q;
    assign busy       = (state_q != IDLE);

    assign idx1 = {k_q, 1'b0};
    assign idx2 = {k_q, 1'b1};

`ifdef FFT_OUT_BITREV_EN
    function automatic logic [address_width-1:0] bit_reverse(input logic [address_width-1:0] v);
        logic [address_width-1:0] r;
        for (int i = 0; i < address_width; i++) begin
            r[i] = v[address_width-1-i];
        end
        return r;
    endfunction

    assign rd_addr1 = bit_reverse(idx1);
    assign rd_addr2 = bit_reverse(idx2);
`else
    assign rd_addr1 = idx1;
    assign rd_addr2 = idx2;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && en) state_d = READ;
            READ:    if (last_issue)  state_d = DRAIN;
            DRAIN:   if (drain_exit)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            out1       <= '0;
            out2       <= '0;
            tail1_q    <= '0;
            tail2_q    <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            done       <= drain_exit;
            // RAM latency cannot be stalled, so the landing is not gated by en
            inflight_q <= rd_en;

            if (last_issue) begin
                k_q <= '0;
            end else if (rd_en) begin
                k_q <= k_q + KW'(1);
            end

            // out1/out2 are the FIFO head; tail holds the second entry
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        out1 <= rd_data1;
                        out2 <= rd_data2;
                    end else begin
                        tail1_q <= rd_data1;
                        tail2_q <= rd_data2;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    out1    <= tail1_q;
                    out2    <= tail2_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        out1 <= rd_data1;
                        out2 <= rd_data2;
                    end else begin
                        out1    <= tail1_q;
                        out2    <= tail2_q;
                        tail1_q <= rd_data1;
                        tail2_q <= rd_data2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output.sv
// Bench for fft_output: behavioural RAM plus an ordered-stream reference model,
// with randomized ready/enable stimulus.
module tb_fft_output;

    localparam int N     = 32;
    localparam int WS    = 16;
    localparam int AW    = $clog2(N);
    localparam int PAIRS = N / 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              start;
    logic              rd_en;
    logic [AW-1:0]     rd_addr1;
    logic [AW-1:0]     rd_addr2;
    logic [2*WS-1:0]   rd_data1;
    logic [2*WS-1:0]   rd_data2;
    logic [2*WS-1:0]   out1;
    logic [2*WS-1:0]   out2;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    fft_output #(.N(N), .word_size(WS), .address_width(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .out1      (out1),
        .out2      (out2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [2*WS-1:0] mem [N];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem[rd_addr1];
            rd_data2 <= mem[rd_addr2];
        end
    end

    // natural index -> RAM location
    function automatic int map_idx(input int i);
`ifdef FFT_OUT_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) begin
            if ((i & (1 << b)) != 0) r = r | (1 << (AW - 1 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    function automatic logic [2*WS-1:0] word_of(input int i);
        logic [WS-1:0] re;
        logic [WS-1:0] im;
        re = WS'(i);
        im = WS'(-i);
        return {re, im};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    // monitor record
    int               cyc;
    logic [2*AW-1:0]  addr_q [$];
    logic [4*WS-1:0]  got_q  [$];
    int rd_cnt, acc_cnt, done_cnt, done_cyc;
    int first_rd_cyc, first_valid_cyc, last_acc_cyc, busy_rise_cyc, busy_fall_cyc;
    int rd_when_dis, hold_viol, freeze_viol, max_occ;
    logic p_valid, p_pop, p_en, p_rd, pp_rd, p_busy;
    logic [2*WS-1:0] p_out1, p_out2;
    logic [AW-1:0]   p_addr1;

    task automatic clear_mon();
        cyc = 0;
        addr_q.delete();
        got_q.delete();
        rd_cnt = 0; acc_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_rd_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
        busy_rise_cyc = -1; busy_fall_cyc = -1;
        rd_when_dis = 0; hold_viol = 0; freeze_viol = 0; max_occ = 0;
        p_valid = 1'b0; p_pop = 1'b0; p_en = 1'b1; p_rd = 1'b0; pp_rd = 1'b0; p_busy = 1'b0;
        p_out1 = '0; p_out2 = '0; p_addr1 = '0;
    endtask

    // one cycle: drive inputs after the falling edge, observe before the rising edge
    task automatic step(input logic r, input logic e, input logic s);
        logic pop;
        @(negedge clk);
        out_ready = r;
        en        = e;
        start     = s;
        #1;
        cyc++;
        pop = out_valid & out_ready & en;
        if (p_valid && !p_pop && (out_valid !== 1'b1 || out1 !== p_out1 || out2 !== p_out2))
            hold_viol++;
        if (!p_en && !pp_rd && (out_valid !== p_valid || out1 !== p_out1 || out2 !== p_out2 || rd_addr1 !== p_addr1))
            freeze_viol++;
        if (rd_en) begin
            addr_q.push_back({rd_addr1, rd_addr2});
            rd_cnt++;
            if (!en) rd_when_dis++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop) begin
            got_q.push_back({out1, out2});
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (rd_cnt - acc_cnt > max_occ) max_occ = rd_cnt - acc_cnt;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !p_busy) busy_rise_cyc = cyc;
        if (!busy && p_busy) busy_fall_cyc = cyc;
        pp_rd = p_rd; p_rd = rd_en; p_en = en; p_busy = busy;
        p_valid = out_valid; p_pop = pop; p_out1 = out1; p_out2 = out2; p_addr1 = rd_addr1;
    endtask

    task automatic run_until_done(input int ready_pct, input int en_pct, input int restart_at,
                                  input int budget, output bit timed_out);
        logic r, e, s;
        while (done_cnt == 0 && cyc < budget) begin
            r = ($urandom_range(99) < ready_pct);
            e = ($urandom_range(99) < en_pct);
            s = (restart_at >= 0 && acc_cnt == restart_at);
            step(r, e, s);
        end
        timed_out = (done_cnt == 0);
        repeat (5) step(1'b1, 1'b1, 1'b0);
    endtask

    function automatic int count_bad_pairs();
        int bad;
        bad = 0;
        for (int k = 0; k < PAIRS; k++) begin
            if (k >= got_q.size()) bad++;
            else if (got_q[k] !== {word_of(2*k), word_of(2*k+1)}) bad++;
        end
        return bad;
    endfunction

    function automatic int count_bad_addrs();
        int bad;
        bad = 0;
        for (int k = 0; k < PAIRS; k++) begin
            if (k >= addr_q.size()) bad++;
            else if (addr_q[k] !== {AW'(map_idx(2*k)), AW'(map_idx(2*k+1))}) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        n_checks++; if (rd_en !== 1'b0)      begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_checks++; if (rd_addr1 !== AW'(0)) begin n_fail++; $display("FAIL reset_addr1: got %0d want 0", rd_addr1); end
        n_checks++; if (rd_addr2 !== AW'(map_idx(1))) begin n_fail++; $display("FAIL reset_addr2: got %0d want %0d", rd_addr2, map_idx(1)); end
        n_checks++; if (out1 !== '0 || out2 !== '0) begin n_fail++; $display("FAIL reset_out: got %h/%h want 0/0", out1, out2); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
        @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        n_checks++; if (rd_cnt !== 0 || busy_rise_cyc !== -1) begin n_fail++; $display("FAIL idle_quiet: reads %0d busy_rise %0d want 0/-1", rd_cnt, busy_rise_cyc); end
    endtask

    task automatic test_stream();
        bit to;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        run_until_done(100, 100, -1, 200, to);
        n_checks++; if (to)                       begin n_fail++; $display("FAIL stream_timeout: no done within budget"); end
        n_checks++; if (got_q.size() !== PAIRS)   begin n_fail++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), PAIRS); end
        n_checks++; if (count_bad_pairs() !== 0)  begin n_fail++; $display("FAIL stream_data: %0d bad pairs want 0", count_bad_pairs()); end
        n_checks++; if (count_bad_addrs() !== 0)  begin n_fail++; $display("FAIL stream_addr: %0d bad addrs want 0", count_bad_addrs()); end
        n_checks++; if (rd_cnt !== PAIRS)         begin n_fail++; $display("FAIL stream_reads: got %0d want %0d", rd_cnt, PAIRS); end
        n_checks++; if (busy_rise_cyc !== 2 || first_rd_cyc !== 2) begin n_fail++; $display("FAIL stream_first_rd: busy %0d rd %0d want 2/2", busy_rise_cyc, first_rd_cyc); end
        n_checks++; if (first_valid_cyc !== 4)    begin n_fail++; $display("FAIL stream_first_valid: got %0d want 4", first_valid_cyc); end
        n_checks++; if (last_acc_cyc !== 3 + PAIRS) begin n_fail++; $display("FAIL stream_last_valid: got %0d want %0d", last_acc_cyc, 3 + PAIRS); end
        n_checks++; if (done_cyc !== 5 + PAIRS || done_cnt !== 1) begin n_fail++; $display("FAIL stream_done: cyc %0d cnt %0d want %0d/1", done_cyc, done_cnt, 5 + PAIRS); end
        n_checks++; if (busy_fall_cyc !== 5 + PAIRS) begin n_fail++; $display("FAIL stream_busy_fall: got %0d want %0d", busy_fall_cyc, 5 + PAIRS); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        for (int c = 2; c <= 12; c++) begin
            step(!(c >= 5 && c <= 9), 1'b1, 1'b0);
            if (c == 9) begin
                n_checks++; if (out_valid !== 1'b1 || out1 !== word_of(2) || out2 !== word_of(3)) begin
                    n_fail++; $display("FAIL bp_hold_pair1: got %b %h/%h want 1 %h/%h", out_valid, out1, out2, word_of(2), word_of(3)); end
                n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL bp_reads_stalled: got %0d want 3", rd_cnt); end
            end
        end
        run_until_done(60, 100, -1, 300, to);
        n_checks++; if (to)                      begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
        n_checks++; if (count_bad_pairs() !== 0 || got_q.size() !== PAIRS) begin n_fail++; $display("FAIL bp_data: %0d bad, %0d pairs want 0/%0d", count_bad_pairs(), got_q.size(), PAIRS); end
        n_checks++; if (max_occ > 2)             begin n_fail++; $display("FAIL bp_occupancy: got %0d want <=2", max_occ); end
        n_checks++; if (hold_viol !== 0)         begin n_fail++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
        n_checks++; if (rd_cnt !== PAIRS || done_cnt !== 1) begin n_fail++; $display("FAIL bp_reads_done: %0d/%0d want %0d/1", rd_cnt, done_cnt, PAIRS); end
    endtask

    task automatic test_enable();
        bit to;
        int rd_before;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        rd_before = rd_cnt;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        n_checks++; if (rd_cnt !== rd_before)    begin n_fail++; $display("FAIL en_low_reads: got %0d want %0d", rd_cnt, rd_before); end
        run_until_done(80, 70, -1, 400, to);
        n_checks++; if (to)                      begin n_fail++; $display("FAIL en_timeout: no done within budget"); end
        n_checks++; if (rd_when_dis !== 0)       begin n_fail++; $display("FAIL en_rd_disabled: got %0d want 0", rd_when_dis); end
        n_checks++; if (freeze_viol !== 0)       begin n_fail++; $display("FAIL en_freeze: got %0d violations want 0", freeze_viol); end
        n_checks++; if (count_bad_pairs() !== 0 || got_q.size() !== PAIRS) begin n_fail++; $display("FAIL en_data: %0d bad, %0d pairs want 0/%0d", count_bad_pairs(), got_q.size(), PAIRS); end
        n_checks++; if (count_bad_addrs() !== 0 || rd_cnt !== PAIRS) begin n_fail++; $display("FAIL en_addr: %0d bad, %0d reads want 0/%0d", count_bad_addrs(), rd_cnt, PAIRS); end
    endtask

    task automatic test_restart_ignored();
        bit to;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        run_until_done(100, 100, 4, 200, to);
        n_checks++; if (to)                      begin n_fail++; $display("FAIL restart_timeout: no done within budget"); end
        n_checks++; if (got_q.size() !== PAIRS || count_bad_pairs() !== 0) begin n_fail++; $display("FAIL restart_data: %0d pairs, %0d bad want %0d/0", got_q.size(), count_bad_pairs(), PAIRS); end
        n_checks++; if (done_cnt !== 1 || rd_cnt !== PAIRS) begin n_fail++; $display("FAIL restart_done: %0d dones %0d reads want 1/%0d", done_cnt, rd_cnt, PAIRS); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        while (acc_cnt < 7 && cyc < 100) step(1'b1, 1'b1, 1'b0);
        n_checks++; if (acc_cnt !== 7) begin n_fail++; $display("FAIL rstmid_reach: got %0d pairs want 7", acc_cnt); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: valid %b busy %b rd_en %b want 0/0/0", out_valid, busy, rd_en); end
        n_checks++; if (out1 !== '0 || out2 !== '0 || rd_addr1 !== AW'(0)) begin n_fail++; $display("FAIL rstmid_data: %h/%h addr %0d want 0/0/0", out1, out2, rd_addr1); end
        @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        step(1'b1, 1'b1, 1'b1);
        run_until_done(100, 100, -1, 200, to);
        n_checks++; if (to)                      begin n_fail++; $display("FAIL rstmid_timeout: no done within budget"); end
        n_checks++; if (got_q.size() !== PAIRS || count_bad_pairs() !== 0 || count_bad_addrs() !== 0) begin n_fail++; $display("FAIL rstmid_stream: %0d pairs, %0d bad want %0d/0", got_q.size(), count_bad_pairs(), PAIRS); end
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int run = 0; run < 3; run++) begin
            clear_mon();
            step(1'b1, 1'b1, 1'b1);
            run_until_done(50, 85, -1, 600, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout run %0d: no done within budget", run); end
            n_checks++; if (got_q.size() !== PAIRS || count_bad_pairs() !== 0) begin n_fail++; $display("FAIL b2b_data run %0d: %0d pairs, %0d bad want %0d/0", run, got_q.size(), count_bad_pairs(), PAIRS); end
            n_checks++; if (max_occ > 2 || hold_viol !== 0 || freeze_viol !== 0 || rd_when_dis !== 0) begin
                n_fail++; $display("FAIL b2b_protocol run %0d: occ %0d hold %0d freeze %0d rd_dis %0d want <=2/0/0/0", run, max_occ, hold_viol, freeze_viol, rd_when_dis); end
            n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done run %0d: got %0d want 1", run, done_cnt); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) mem[map_idx(i)] = word_of(i);
        clear_mon();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_enable();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
